// File: rtl/iec_floppy_bridge_if.sv
// iec_floppy_bridge_if: IEC serial bus lines between a talker/controller and the bridge
interface iec_floppy_bridge_if;
    logic ATN_IN, CLK_IN, DATA_IN, SRQ_IN;
    logic CLK_OUT, DATA_OUT, SRQ_OUT;
    modport master (output ATN_IN, CLK_IN, DATA_IN, SRQ_IN, input CLK_OUT, DATA_OUT, SRQ_OUT);
    modport slave (input ATN_IN, CLK_IN, DATA_IN, SRQ_IN, output CLK_OUT, DATA_OUT, SRQ_OUT);
endinterface

// File: rtl/iec_floppy_bridge.sv
// iec_floppy_bridge: IEC listener that decodes LISTEN/UNLISTEN and seeks a Shugart drive head
module iec_floppy_bridge #(
    parameter int CYCLES_PER_US = 50,
    parameter int STEP_PULSE_US = 4,
    parameter int STEP_RATE_US = 3000,
    parameter int MAX_TRACK = 83,
    parameter int EOI_US = 200
) (
    input  logic clk,
    input  logic RESET_IN,
    iec_floppy_bridge_if.slave iec,
    output logic PWR_LED,
    output logic ACTION_LED,
    input  logic DSKCHG, RDATA, WPT, TRK00, INDEX,
    input  logic REDWC_IN,
    output logic REDWC_OUT,
    input  logic SW0, SW1,
    output logic SIDE1, WGATE, WDATE, STEP, DIR, MOTEA, MOTEB, DRVSA, DRVSB
);
    typedef enum logic [2:0] {R_IDLE, R_WAIT, R_READY, R_EOI, R_EOIW, R_BITS, R_ACK} rx_t;
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_LOW, S_HIGH} sk_t;
    localparam logic [23:0] T_US1 = 24'(CYCLES_PER_US - 1);
    localparam logic [23:0] T_PULSE1 = 24'(STEP_PULSE_US * CYCLES_PER_US - 1);
    localparam logic [23:0] T_RATE1 = 24'(STEP_RATE_US * CYCLES_PER_US - 1);
    localparam logic [23:0] T_EOI1 = 24'(EOI_US * CYCLES_PER_US - 1);
    localparam logic [23:0] T_EOIACK1 = 24'(60 * CYCLES_PER_US - 1);
    localparam logic [6:0] MAX_T = 7'(MAX_TRACK);
    localparam logic [6:0] RECAL_MAX = 7'(MAX_TRACK + 1);
    logic [1:0] rs_q;
    logic rst_n;
    logic [11:0] s1_q, s_q;
    logic atn_s, clk_s, data_s, trk0, unused_ok;
    rx_t rx_q, rx_d;
    sk_t sk_q, sk_d;
    logic [23:0] rcnt_q, rcnt_d, scnt_q, scnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic [6:0] target_q, target_d, track_q, track_d, rc_q, rc_d;
    logic eoi_q, eoi_d, listen_q, listen_d, recal_q, recal_d, dir_q, dir_d;
    logic dout_q, dout_d, atn_q, clkp_q, step_q, mot_q, pwr_q, byte_v;
    // Reset asserts asynchronously and releases on a clock edge
    always_ff @(posedge clk or negedge RESET_IN) begin
        if (!RESET_IN) rs_q <= '0;
        else rs_q <= {rs_q[0], 1'b1};
    end
    assign rst_n = rs_q[1];
    always_ff @(posedge clk) begin
        {s_q, s1_q} <= {s1_q, SW1, SW0, REDWC_IN, INDEX, TRK00, WPT, RDATA, DSKCHG,
                        iec.SRQ_IN, iec.DATA_IN, iec.CLK_IN, iec.ATN_IN};
    end
    assign atn_s = s_q[0];
    assign clk_s = s_q[1];
    assign data_s = s_q[2];
    assign trk0 = ~s_q[7];
    assign unused_ok = ^{s_q[3], s_q[6:4], s_q[8]};
    always_comb begin
        rx_d = rx_q;
        rcnt_d = rcnt_q + 24'd1;
        bit_d = bit_q;
        sh_d = sh_q;
        eoi_d = eoi_q;
        listen_d = listen_q;
        target_d = target_q;
        byte_v = 1'b0;
        case (rx_q)
            R_IDLE: begin
                rcnt_d = '0;
                if (atn_s) rx_d = R_WAIT;
            end
            R_WAIT: begin
                rcnt_d = '0;
                bit_d = '0;
                eoi_d = 1'b0;
                if (!clk_s) rx_d = R_READY;
            end
            R_READY: begin
                if (clk_s) rx_d = R_BITS;
                else if (rcnt_q == T_EOI1) begin
                    rx_d = R_EOI;
                    eoi_d = 1'b1;
                    rcnt_d = '0;
                end
            end
            R_EOI: if (rcnt_q == T_EOIACK1) rx_d = R_EOIW;
            R_EOIW: if (clk_s) rx_d = R_BITS;
            R_BITS: begin
                if (clkp_q && !clk_s) begin
                    sh_d = {~data_s, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_d = R_ACK;
                end
            end
            R_ACK: begin
                if (clk_s) begin
                    byte_v = 1'b1;
                    rx_d = eoi_q ? R_IDLE : R_WAIT;
                end
            end
            default: rx_d = R_IDLE;
        endcase
        // Under ATN only listen-group commands (0x20..0x3F) change the listener state
        if (byte_v && atn_s && sh_q[7:5] == 3'b001) listen_d = (sh_q == {6'b001010, s_q[11:10]});
        if (byte_v && !atn_s && listen_q) target_d = (sh_q > 8'(MAX_TRACK)) ? MAX_T : sh_q[6:0];
        if (atn_s && !atn_q) rx_d = R_WAIT;
        else if (!atn_s && atn_q) rx_d = listen_d ? R_WAIT : R_IDLE;
        dout_d = rx_d == R_WAIT || rx_d == R_EOI || (rx_d == R_IDLE && (atn_s || listen_d));
    end
    always_comb begin
        sk_d = sk_q;
        scnt_d = scnt_q + 24'd1;
        track_d = track_q;
        dir_d = dir_q;
        recal_d = recal_q;
        rc_d = rc_q;
        case (sk_q)
            S_IDLE: begin
                scnt_d = '0;
                if (recal_q) begin
                    if (trk0 || rc_q == RECAL_MAX) begin
                        recal_d = 1'b0;
                        track_d = '0;
                    end else begin
                        dir_d = 1'b1;
                        sk_d = S_SETTLE;
                    end
                end else if (target_q != track_q) begin
                    dir_d = target_q < track_q;
                    sk_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (scnt_q == T_US1) begin
                    sk_d = S_LOW;
                    scnt_d = '0;
                end
            end
            S_LOW: begin
                if (scnt_q == T_PULSE1) begin
                    sk_d = S_HIGH;
                    if (recal_q) rc_d = rc_q + 7'd1;
                    else track_d = dir_q ? ((track_q == 7'd0) ? 7'd0 : track_q - 7'd1) : track_q + 7'd1;
                end
            end
            default: if (scnt_q == T_RATE1) sk_d = S_IDLE;
        endcase
        // Track 0 sensor wins over the step count when heading outward
        if (dir_q && trk0 && sk_q != S_IDLE) track_d = '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= R_IDLE;
            sk_q <= S_IDLE;
            rcnt_q <= '0;
            scnt_q <= '0;
            bit_q <= '0;
            sh_q <= '0;
            target_q <= '0;
            track_q <= '0;
            rc_q <= '0;
            eoi_q <= 1'b0;
            listen_q <= 1'b0;
            recal_q <= 1'b1;
            dir_q <= 1'b1;
            dout_q <= 1'b0;
            atn_q <= 1'b0;
            clkp_q <= 1'b0;
            step_q <= 1'b1;
            mot_q <= 1'b1;
            pwr_q <= 1'b0;
        end else begin
            rx_q <= rx_d;
            sk_q <= sk_d;
            rcnt_q <= rcnt_d;
            scnt_q <= scnt_d;
            bit_q <= bit_d;
            sh_q <= sh_d;
            target_q <= target_d;
            track_q <= track_d;
            rc_q <= rc_d;
            eoi_q <= eoi_d;
            listen_q <= listen_d;
            recal_q <= recal_d;
            dir_q <= dir_d;
            dout_q <= dout_d;
            atn_q <= atn_s;
            clkp_q <= clk_s;
            step_q <= sk_d != S_LOW;
            mot_q <= !(listen_d || recal_d || sk_d != S_IDLE || target_d != track_d);
            pwr_q <= 1'b1;
        end
    end
    assign iec.CLK_OUT = 1'b0;
    assign iec.SRQ_OUT = 1'b0;
    assign iec.DATA_OUT = dout_q;
    assign PWR_LED = pwr_q;
    assign ACTION_LED = ~mot_q;
    assign REDWC_OUT = s_q[9];
    assign SIDE1 = 1'b1;
    assign WGATE = 1'b1;
    assign WDATE = 1'b1;
    assign STEP = step_q;
    assign DIR = dir_q;
    assign MOTEA = mot_q;
    assign DRVSA = mot_q;
    assign MOTEB = 1'b1;
    assign DRVSB = 1'b1;
endmodule

// File: tb/tb_iec_floppy_bridge.sv
// tb_iec_floppy_bridge: directed IEC talker plus a step-counting drive model around the bridge
module tb_iec_floppy_bridge;
    logic clk = 1'b0;
    logic RESET_IN;
    logic DSKCHG = 1'b1, RDATA = 1'b1, WPT = 1'b1, INDEX = 1'b1, TRK00;
    logic REDWC_IN = 1'b0, SW0 = 1'b0, SW1 = 1'b0;
    logic PWR_LED, ACTION_LED, REDWC_OUT;
    logic SIDE1, WGATE, WDATE, STEP, DIR, MOTEA, MOTEB, DRVSA, DRVSB;
    iec_floppy_bridge_if bus();
    iec_floppy_bridge #(.CYCLES_PER_US(2), .STEP_RATE_US(10)) dut (
        .clk(clk), .RESET_IN(RESET_IN), .iec(bus),
        .PWR_LED(PWR_LED), .ACTION_LED(ACTION_LED),
        .DSKCHG(DSKCHG), .RDATA(RDATA), .WPT(WPT), .TRK00(TRK00), .INDEX(INDEX),
        .REDWC_IN(REDWC_IN), .REDWC_OUT(REDWC_OUT), .SW0(SW0), .SW1(SW1),
        .SIDE1(SIDE1), .WGATE(WGATE), .WDATE(WDATE), .STEP(STEP), .DIR(DIR),
        .MOTEA(MOTEA), .MOTEB(MOTEB), .DRVSA(DRVSA), .DRVSB(DRVSB)
    );
    always #5 clk = ~clk;
    int errs = 0, checks = 0;
    int cyc = 0, in_n = 0, out_n = 0, tb_track = 0, last_fall = -1;
    int min_low = 1000000, min_gap = 1000000;
    int in0, out0, rc_exp;
    logic prev_step = 1'b1;
    // Drive model: head moves on each STEP falling edge, TRK00 low at track 0
    always @(negedge clk) begin
        cyc++;
        if (prev_step && !STEP) begin
            if (last_fall >= 0 && cyc - last_fall < min_gap) min_gap = cyc - last_fall;
            last_fall = cyc;
            if (DIR) begin
                out_n++;
                if (tb_track > 0) tb_track--;
            end else begin
                in_n++;
                tb_track++;
            end
        end
        if (!prev_step && STEP && cyc - last_fall < min_low) min_low = cyc - last_fall;
        prev_step = STEP;
    end
    assign TRK00 = (tb_track != 0);
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wait_data(input logic v, input int budget, input string tag);
        for (int i = 0; i < budget && bus.DATA_OUT !== v; i++) cycles(1);
        check(tag, 32'(bus.DATA_OUT), 32'(v));
    endtask
    task automatic send_byte(input logic [7:0] b, input bit eoi);
        bus.CLK_IN = 1'b0;
        wait_data(1'b0, 50, "listener_ready");
        if (eoi) begin
            cycles(300);
            check("eoi_not_early", 32'(bus.DATA_OUT), 0);
            cycles(140);
            check("eoi_ack_pulse", 32'(bus.DATA_OUT), 1);
            cycles(140);
            check("eoi_ack_release", 32'(bus.DATA_OUT), 0);
        end
        bus.CLK_IN = 1'b1;
        cycles(4);
        for (int i = 0; i < 8; i++) begin
            bus.DATA_IN = ~b[i];
            cycles(4);
            bus.CLK_IN = 1'b0;
            cycles(4);
            bus.CLK_IN = 1'b1;
            bus.DATA_IN = 1'b0;
        end
        wait_data(1'b1, 20, "byte_ack");
    endtask
    task automatic atn_cmd(input logic [7:0] b);
        bus.ATN_IN = 1'b1;
        bus.CLK_IN = 1'b1;
        wait_data(1'b1, 4, "atn_ack");
        send_byte(b, 1'b0);
        bus.ATN_IN = 1'b0;
        cycles(6);
    endtask
    initial begin
        RESET_IN = 1'b0;
        bus.ATN_IN = 1'b0;
        bus.CLK_IN = 1'b0;
        bus.DATA_IN = 1'b0;
        bus.SRQ_IN = 1'b0;
        cycles(10);
        check("rst_pwr_led", 32'(PWR_LED), 0);
        check("rst_step", 32'(STEP), 1);
        check("rst_dir", 32'(DIR), 1);
        check("rst_motea", 32'(MOTEA), 1);
        check("rst_data_out", 32'(bus.DATA_OUT), 0);
        RESET_IN = 1'b1;
        cycles(100);
        check("pwr_led_on", 32'(PWR_LED), 1);
        check("fixed_drive_outs", 32'({WGATE, WDATE, SIDE1, MOTEB, DRVSB}), 32'h1f);
        check("fixed_iec_outs", 32'({bus.CLK_OUT, bus.SRQ_OUT}), 0);
        check("recal_no_steps", 32'(in_n + out_n), 0);
        check("recal_track", 32'(tb_track), 0);
        check("idle_motor_off", 32'(MOTEA), 1);
        bus.ATN_IN = 1'b1;
        bus.CLK_IN = 1'b1;
        wait_data(1'b1, 4, "atn_ack_sw00");
        bus.ATN_IN = 1'b0;
        bus.CLK_IN = 1'b0;
        cycles(6);
        check("atn_release_no_listen", 32'(bus.DATA_OUT), 0);
        atn_cmd(8'h28);
        check("listen28_data_held", 32'(bus.DATA_OUT), 1);
        check("listen28_drive_on", 32'({MOTEA, DRVSA, ACTION_LED}), 32'b001);
        SW0 = 1'b1;
        cycles(4);
        atn_cmd(8'h28);
        check("sw01_listen28_off", 32'({MOTEA, ACTION_LED}), 32'b10);
        atn_cmd(8'h29);
        check("sw01_listen29_on", 32'({MOTEA, DRVSA}), 0);
        in0 = in_n;
        out0 = out_n;
        send_byte(8'd5, 1'b0);
        cycles(300);
        check("seek5_in_steps", 32'(in_n - in0), 5);
        check("seek5_out_steps", 32'(out_n - out0), 0);
        check("seek5_track", 32'(tb_track), 5);
        in0 = in_n;
        out0 = out_n;
        send_byte(8'd2, 1'b0);
        cycles(200);
        check("seek2_out_steps", 32'(out_n - out0), 3);
        check("seek2_in_steps", 32'(in_n - in0), 0);
        check("seek2_track", 32'(tb_track), 2);
        in0 = in_n;
        send_byte(8'd200, 1'b0);
        cycles(50);
        atn_cmd(8'h3F);
        check("unlisten_idle_data", 32'(bus.DATA_OUT), 0);
        check("unlisten_busy_motor_on", 32'(MOTEA), 0);
        cycles(2200);
        check("clamp_steps", 32'(in_n - in0), 81);
        check("clamp_track", 32'(tb_track), 83);
        check("unlisten_motor_off", 32'({MOTEA, ACTION_LED}), 32'b10);
        check("step_low_min", 32'(min_low >= 8), 1);
        check("step_period_min", 32'(min_gap >= 20), 1);
        atn_cmd(8'h29);
        send_byte(8'd80, 1'b1);
        bus.CLK_IN = 1'b0;
        cycles(10);
        check("eoi_back_to_idle", 32'(bus.DATA_OUT), 1);
        for (int i = 0; i < 40 && STEP !== 1'b0; i++) cycles(1);
        check("eoi_seek_step", 32'(STEP), 0);
        check("eoi_seek_dir_out", 32'(DIR), 1);
        cycles(1);
        RESET_IN = 1'b0;
        #1;
        check("midrst_step_release", 32'(STEP), 1);
        check("midrst_motor_off", 32'(MOTEA), 1);
        check("midrst_pwr_led", 32'(PWR_LED), 0);
        check("midrst_data_out", 32'(bus.DATA_OUT), 0);
        rc_exp = tb_track;
        out0 = out_n;
        cycles(5);
        RESET_IN = 1'b1;
        cycles(2100);
        check("recal_to_trk00", 32'(tb_track), 0);
        check("recal_steps", 32'(out_n - out0), 32'(rc_exp));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/iec_floppy_bridge.md
Name: iec_floppy_bridge

Overview:
- Top-level bridge between the Commodore IEC serial bus and a PC (Shugart 34-pin) floppy drive.
- Acts as an IEC listener at device 8+{SW1,SW0} and acknowledges ATN.
- Decodes LISTEN/UNLISTEN, turns on drive A, and seeks the head to the track number received as a data byte.
- Provides power and activity LEDs.

Parameters:
- CYCLES_PER_US, 50: clk cycles per microsecond; all timers count whole microseconds.
- STEP_PULSE_US, 4: STEP low width.
- STEP_RATE_US, 3000: minimum STEP period, falling edge to falling edge.
- MAX_TRACK, 83: highest seekable track; recalibrate gives up after MAX_TRACK+1 steps.
- EOI_US, 200: listener-ready wait before the EOI condition is declared.

Ports:
- clk in 1: system clock.
- RESET_IN in 1: asynchronous, active-low reset.
- ATN_IN, CLK_IN, DATA_IN, SRQ_IN in 1: IEC lines as received; 1 = line asserted (electrically low).
- CLK_OUT, DATA_OUT, SRQ_OUT out 1: open-collector drive; 1 = pull line low.
- PWR_LED out 1: 1 = on.
- ACTION_LED out 1: 1 = on.
- DSKCHG, RDATA, WPT, TRK00, INDEX in 1: drive status, active-low.
- REDWC_IN in 1: density select request.
- REDWC_OUT out 1: density select to drive.
- SW0, SW1 in 1: device-number offset.
- SIDE1, WGATE, WDATE, STEP, DIR, MOTEA, MOTEB, DRVSA, DRVSB out 1: drive controls, active-low; DIR=1 means outward (toward track 0).

Behaviour:
- Input synchronisation: every input except clk passes through a 2-FF synchroniser. All logic uses only the synchronised values.
- Reset values: CLK_OUT=DATA_OUT=SRQ_OUT=0; all drive outputs 1; PWR_LED=0; ACTION_LED=0; listening=0; track=0; target=0.
- Out of reset: PWR_LED=1.
- Fixed outputs: SIDE1=WGATE=WDATE=1 (side 0, never writes). MOTEB=DRVSB=1. SRQ_OUT=0 and CLK_OUT=0 always (listener only).
- REDWC_OUT = synchronised REDWC_IN.
- Unused inputs: RDATA, WPT, DSKCHG are ignored.
- ATN handling: while ATN_IN=1, the IEC receiver is forced into ATN mode. DATA_OUT=1 within 2 cycles of synchronised ATN rising, regardless of device number.
- IEC receiver FSM:
  - IDLE: DATA_OUT=0 unless ATN or listening.
  - WAIT_TALKER: hold DATA_OUT=1 until CLK_IN=0 (talker ready).
  - READY: release DATA_OUT. If CLK_IN=1 before EOI_US, go to BITS. If EOI_US elapses, set eoi=1, assert DATA_OUT for 60 us, release it, then wait for CLK_IN=1.
  - BITS: sample DATA_IN on each CLK_IN 1->0 (line released). Bit value = NOT DATA_IN. 8 bits, LSB first.
  - ACK: after the 8th bit wait for CLK_IN=1, then set DATA_OUT=1 and emit byte_valid for one cycle. Return to WAIT_TALKER. After an eoi byte, go to IDLE.
- ATN falling edge from any state: go to IDLE if not listening, else WAIT_TALKER.
- Command bytes received with ATN asserted:
  - 0x20|dev, where dev=8+{SW1,SW0}: sets listening=1.
  - 0x20|other device: sets listening=0.
  - 0x3F (UNLISTEN): sets listening=0.
  - Any other value: ignored.
- Data bytes (ATN deasserted, listening=1): target = min(byte, MAX_TRACK). Starts a seek; a new target during a seek replaces the old one at the next step decision.
- Drive enable: MOTEA=DRVSA=0 while listening or seek is busy. ACTION_LED = ~MOTEA.
- Seek FSM:
  - RECAL is entered on reset release: DIR=1; step while TRK00=1. When TRK00=0, track=0 and go to IDLE. After MAX_TRACK+1 steps without TRK00, track=0 and go to IDLE (error tolerated).
  - IDLE: if target!=track, go to STEP.
  - STEP: DIR=(target<track). DIR is settled 1 us before STEP goes low. STEP=0 for STEP_PULSE_US, then 1. track±1 when STEP goes high. Wait until STEP_RATE_US has elapsed since the falling edge, then return to IDLE.
  - track is an unsigned 7-bit value.
  - While stepping outward, if TRK00=0 is sampled with track!=0, force track=0.
- Reset mid-operation: all state is cleared immediately. STEP is released combinationally through the reset values. Recalibration restarts after reset release.

Test Plan:
- Reset, with CYCLES_PER_US=2, STEP_RATE_US=10, TRK00=0 held -> after reset release PWR_LED=1; WGATE=WDATE=SIDE1=1; zero STEP pulses; track=0.
- ATN_IN=1 with SW=00 -> DATA_OUT=1 within 4 cycles of the ATN edge. Release ATN with no LISTEN -> DATA_OUT=0.
- Under ATN, bit-bang byte 0x28 (8 bits LSB first, CLK handshakes) -> DATA_OUT asserted after the bit frame; listening=1; MOTEA=DRVSA=0; ACTION_LED=1. Repeat with SW=01 -> 0x28 ignored, 0x29 accepted.
- With listening=1, ATN released, send data byte 5 -> exactly 5 STEP pulses with DIR=0, each ≥4 us low and ≥10 us apart. Then send 2 -> 3 pulses with DIR=1.
- Send data byte 200 -> seek clamps to track 83. Then UNLISTEN 0x3F -> listening=0; motor off after the seek finishes.
- EOI: talker delays CLK assertion beyond 200 us -> DATA_OUT pulses 60 us, the byte is received, and the receiver returns to IDLE.
